// File: rtl/instr_decode.sv
// Decode stage: control decode, register file, hazard detection,
// early branch resolution and the ID/EX pipeline register.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_pc_plus_4,
    input  logic [31:0] if_id_instr,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_to_reg,
    input  logic [4:0]  ex_mem_write_reg,
    input  logic [31:0] ex_mem_alu_out,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_result,
    output logic        stall_if,
    output logic        stall_id,
    output logic        pc_src,
    output logic        jump,
    output logic [31:0] pc_branch,
    output logic [31:0] pc_jump,
    output logic [7:0]  id_ex_ctrl,
    output logic [31:0] id_ex_rd1,
    output logic [31:0] id_ex_rd2,
    output logic [31:0] id_ex_imm,
    output logic [14:0] id_ex_regs
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic        is_r, is_lw, is_sw, is_beq, is_addi;

    assign op      = if_id_instr[31:26];
    assign funct   = if_id_instr[5:0];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign imm_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    assign is_r    = (op == OP_R);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_addi = (op == OP_ADDI);

    // {reg_write, mem_to_reg, mem_write, alu_ctrl, alu_src, reg_dst}
    logic [7:0] ctrl_d;
    always_comb begin
        ctrl_d = '0;
        unique case (1'b1)
            is_r: begin
                unique case (funct)
                    6'b100000: ctrl_d = 8'b1000_1001;
                    6'b100010: ctrl_d = 8'b1001_1001;
                    6'b100100: ctrl_d = 8'b1000_0001;
                    6'b100101: ctrl_d = 8'b1000_0101;
                    6'b101010: ctrl_d = 8'b1001_1101;
                    default:   ctrl_d = '0;
                endcase
            end
            is_lw:   ctrl_d = 8'b1100_1010;
            is_sw:   ctrl_d = 8'b0010_1010;
            is_addi: ctrl_d = 8'b1000_1010;
            is_beq:  ctrl_d = 8'b0001_1000;
            default: ctrl_d = '0;
        endcase
    end

    logic [31:0] rf_q [32];
    logic [31:0] rd1_d, rd2_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_reg_write && wb_write_reg != 5'd0) begin
            rf_q[wb_write_reg] <= wb_result;
        end
    end

    // Same-cycle WB write bypasses the array
    assign rd1_d = (rs == 5'd0) ? 32'd0 :
                   (wb_reg_write && wb_write_reg == rs) ? wb_result :
                   rf_q[rs];
    assign rd2_d = (rt == 5'd0) ? 32'd0 :
                   (wb_reg_write && wb_write_reg == rt) ? wb_result :
                   rf_q[rt];

    logic        fwd_a, fwd_b;
    logic [31:0] cmp_a, cmp_b;

    assign fwd_a = ex_mem_reg_write && ex_mem_write_reg != 5'd0
                   && ex_mem_write_reg == rs;
    assign fwd_b = ex_mem_reg_write && ex_mem_write_reg != 5'd0
                   && ex_mem_write_reg == rt;
    assign cmp_a = fwd_a ? ex_mem_alu_out : rd1_d;
    assign cmp_b = fwd_b ? ex_mem_alu_out : rd2_d;

    logic [4:0] ex_rt, ex_rd, ex_dst;
    logic       lwstall, brstall, mem_hit, ex_hit, stall;

    assign ex_rt  = id_ex_regs[9:5];
    assign ex_rd  = id_ex_regs[4:0];
    assign ex_dst = id_ex_ctrl[0] ? ex_rd : ex_rt;

    assign lwstall = id_ex_ctrl[6] && ex_rt != 5'd0
                     && (ex_rt == rs || ex_rt == rt);
    assign ex_hit  = id_ex_ctrl[7] && ex_dst != 5'd0
                     && (ex_dst == rs || ex_dst == rt);
    assign mem_hit = ex_mem_mem_to_reg && ex_mem_write_reg != 5'd0
                     && (ex_mem_write_reg == rs || ex_mem_write_reg == rt);
    assign brstall = is_beq && (ex_hit || mem_hit);
    assign stall   = lwstall || brstall;

    assign stall_if  = ~stall;
    assign stall_id  = ~stall;
    assign pc_src    = is_beq && (cmp_a == cmp_b) && !stall;
    assign jump      = (op == OP_J);
    assign pc_branch = if_id_pc_plus_4 + {imm_ext[29:0], 2'b00};
    assign pc_jump   = {if_id_pc_plus_4[31:28], if_id_instr[25:0], 2'b00};

    logic [7:0]  ctrl_q;
    logic [31:0] rd1_q, rd2_q, imm_q;
    logic [14:0] regs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            regs_q <= '0;
        end else begin
            ctrl_q <= stall ? 8'd0 : ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_ext;
            regs_q <= {rs, rt, rd};
        end
    end

    assign id_ex_ctrl = ctrl_q;
    assign id_ex_rd1  = rd1_q;
    assign id_ex_rd2  = rd2_q;
    assign id_ex_imm  = imm_q;
    assign id_ex_regs = regs_q;
endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed pipeline scenarios plus
// randomized traffic against a behavioural decode-stage model.
module tb_instr_decode;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_pc_plus_4, if_id_instr;
    logic        ex_mem_reg_write, ex_mem_mem_to_reg;
    logic [4:0]  ex_mem_write_reg;
    logic [31:0] ex_mem_alu_out;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_result;
    logic        stall_if, stall_id, pc_src, jump;
    logic [31:0] pc_branch, pc_jump;
    logic [7:0]  id_ex_ctrl;
    logic [31:0] id_ex_rd1, id_ex_rd2, id_ex_imm;
    logic [14:0] id_ex_regs;

    always #5 clk = ~clk;

    instr_decode dut (
        .clk(clk), .reset(reset),
        .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_instr(if_id_instr),
        .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
        .ex_mem_write_reg(ex_mem_write_reg),
        .ex_mem_alu_out(ex_mem_alu_out),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_result(wb_result),
        .stall_if(stall_if), .stall_id(stall_id),
        .pc_src(pc_src), .jump(jump),
        .pc_branch(pc_branch), .pc_jump(pc_jump),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_rd1(id_ex_rd1),
        .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm),
        .id_ex_regs(id_ex_regs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: architectural registers and the instruction in EX
    logic [31:0] m_rf [32];
    logic [7:0]  m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [14:0] m_regs;
    bit          m_valid;
    bit          m_ex_load;
    logic [4:0]  m_ex_dest;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_ctrl(input logic [31:0] ins);
        logic rw, mtr, mw, src, dst, ok;
        logic [2:0] alu;
        {rw, mtr, mw, src, dst} = '0;
        alu = 3'b000;
        ok  = 1'b1;
        case (ins[31:26])
            6'b000000: begin
                rw = 1; dst = 1;
                case (ins[5:0])
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   ok = 0;
                endcase
            end
            6'b100011: begin rw = 1; mtr = 1; src = 1; alu = 3'b010; end
            6'b101011: begin mw = 1; src = 1; alu = 3'b010; end
            6'b001000: begin rw = 1; src = 1; alu = 3'b010; end
            6'b000100: alu = 3'b110;
            default:   ok = 0;
        endcase
        return ok ? {rw, mtr, mw, alu, src, dst} : 8'h00;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_reg_write && wb_write_reg == r) return wb_result;
        return m_rf[r];
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (ex_mem_reg_write && ex_mem_write_reg != 0
            && ex_mem_write_reg == r)
            return ex_mem_alu_out;
        return rf_read(r);
    endfunction

    function automatic bit uses(input logic [4:0] r);
        return r != 5'd0 && (r == if_id_instr[25:21]
                             || r == if_id_instr[20:16]);
    endfunction

    function automatic bit exp_stall();
        bit beq;
        beq = if_id_instr[31:26] == 6'b000100;
        if (m_ex_load && uses(m_ex_dest)) return 1;
        if (beq && uses(m_ex_dest)) return 1;
        if (beq && ex_mem_mem_to_reg && uses(ex_mem_write_reg)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_regs = '0;
        m_valid = 1; m_ex_load = 0; m_ex_dest = '0;
    endtask

    task automatic compare_model();
        logic [31:0] sx, a, b;
        bit st, beq;
        sx  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        st  = exp_stall();
        beq = if_id_instr[31:26] == 6'b000100;
        a   = operand(if_id_instr[25:21]);
        b   = operand(if_id_instr[20:16]);
        chk("stall_if", 32'(stall_if), 32'(!st));
        chk("stall_id", 32'(stall_id), 32'(!st));
        chk("pc_src", 32'(pc_src), 32'(beq && a == b && !st));
        chk("jump", 32'(jump), 32'(if_id_instr[31:26] == 6'b000010));
        chk("pc_branch", pc_branch, if_id_pc_plus_4 + sx * 4);
        chk("pc_jump", pc_jump,
            {if_id_pc_plus_4[31:28], if_id_instr[25:0], 2'b00});
        chk("id_ex_ctrl", 32'(id_ex_ctrl), 32'(m_ctrl));
        if (m_valid) begin
            chk("id_ex_rd1", id_ex_rd1, m_rd1);
            chk("id_ex_rd2", id_ex_rd2, m_rd2);
            chk("id_ex_imm", id_ex_imm, m_imm);
            chk("id_ex_regs", 32'(id_ex_regs), 32'(m_regs));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_model();
    endtask

    // Commit what the upcoming edge does, then cross it
    task automatic adv();
        logic [7:0] c;
        logic [4:0] rs, rt, rd;
        rs = if_id_instr[25:21];
        rt = if_id_instr[20:16];
        rd = if_id_instr[15:11];
        if (reset) begin
            c = ref_ctrl(if_id_instr);
            if (exp_stall()) begin
                m_ctrl = 0; m_valid = 0; m_ex_load = 0; m_ex_dest = 0;
            end else begin
                m_ctrl  = c;
                m_rd1   = rf_read(rs);
                m_rd2   = rf_read(rt);
                m_imm   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
                m_regs  = {rs, rt, rd};
                m_valid = 1;
                m_ex_load = if_id_instr[31:26] == 6'b100011;
                m_ex_dest = !c[7] ? 5'd0 : (c[0] ? rd : rt);
            end
            if (wb_reg_write && wb_write_reg != 0)
                m_rf[wb_write_reg] = wb_result;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic side_clear();
        ex_mem_reg_write = 0; ex_mem_mem_to_reg = 0;
        ex_mem_write_reg = 0; ex_mem_alu_out = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_result = 0;
    endtask

    task automatic wb_set(input logic [4:0] r, input logic [31:0] v);
        wb_reg_write = 1; wb_write_reg = r; wb_result = v;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s,
        input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o,
        input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
        return {o, s, t, i};
    endfunction

    task automatic rand_inputs();
        logic [5:0] fn [5];
        logic [4:0] s, t, d;
        int k;
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        s = 5'($urandom_range(0, 3));
        t = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        case (k)
            0, 1: if_id_instr = rtype(s, t, d, fn[$urandom_range(0, 4)]);
            2: if_id_instr = rtype(s, t, d, 6'($urandom));
            3: if_id_instr = itype(6'b100011, s, t, 16'($urandom));
            4: if_id_instr = itype(6'b101011, s, t, 16'($urandom));
            5, 6: if_id_instr = itype(6'b000100, s, t, 16'($urandom));
            7: if_id_instr = itype(6'b001000, s, t, 16'($urandom));
            8: if_id_instr = {6'b000010, 26'($urandom)};
            default: if_id_instr = $urandom;
        endcase
        if_id_pc_plus_4   = $urandom & 32'hFFFF_FFFC;
        ex_mem_reg_write  = 1'($urandom);
        ex_mem_mem_to_reg = 1'($urandom);
        ex_mem_write_reg  = 5'($urandom_range(0, 3));
        ex_mem_alu_out    = $urandom_range(0, 3);
        wb_reg_write      = 1'($urandom);
        wb_write_reg      = 5'($urandom_range(0, 3));
        wb_result         = ($urandom_range(0, 1) == 0)
                            ? $urandom_range(0, 3) : $urandom;
        reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        if (!reset) model_reset();
    endtask

    initial begin
        reset = 0;
        if_id_instr = '0;
        if_id_pc_plus_4 = '0;
        side_clear();
        model_reset();

        settle();
        chk("reset_ctrl", 32'(id_ex_ctrl), 32'h0);
        chk("reset_rd1", id_ex_rd1, 32'h0);
        adv();
        reset = 1;

        // r1 = r2 = 5
        if_id_instr = NOP;
        wb_set(5'd1, 32'd5);
        settle(); adv();
        wb_set(5'd2, 32'd5);
        settle(); adv();
        side_clear();

        // taken beq r1,r2,+3
        if_id_instr = itype(6'b000100, 5'd1, 5'd2, 16'd3);
        if_id_pc_plus_4 = 32'h40;
        settle();
        chk("beq_pc_src", 32'(pc_src), 32'h1);
        chk("beq_target", pc_branch, 32'h4C);
        adv();

        // lw r2 then dependent add r3,r2,r4
        if_id_instr = itype(6'b100011, 5'd1, 5'd2, 16'd0);
        settle(); adv();
        if_id_instr = rtype(5'd2, 5'd4, 5'd3, 6'b100000);
        settle();
        chk("lw_stall_if", 32'(stall_if), 32'h0);
        chk("lw_stall_id", 32'(stall_id), 32'h0);
        adv();
        settle();
        chk("lw_bubble", 32'(id_ex_ctrl), 32'h0);
        chk("lw_released", 32'(stall_if), 32'h1);
        adv();
        settle();
        chk("add_ctrl", 32'(id_ex_ctrl), 32'h89);
        adv();

        // add r1 in EX while beq r1 decodes
        if_id_instr = rtype(5'd2, 5'd2, 5'd1, 6'b100000);
        settle(); adv();
        if_id_instr = itype(6'b000100, 5'd1, 5'd2, 16'd3);
        settle();
        chk("brdep_stall", 32'(stall_if), 32'h0);
        chk("brdep_no_take", 32'(pc_src), 32'h0);
        adv();
        ex_mem_reg_write = 1; ex_mem_write_reg = 5'd1;
        ex_mem_alu_out = 32'd10;
        settle();
        chk("brfwd_stall", 32'(stall_if), 32'h1);
        chk("brfwd_ne", 32'(pc_src), 32'h0);
        ex_mem_alu_out = 32'd5;
        #1;
        chk("brfwd_eq", 32'(pc_src), 32'h1);
        adv();
        side_clear();

        // jump
        if_id_instr = {6'b000010, 26'h000_0010};
        if_id_pc_plus_4 = 32'h8000_0004;
        settle();
        chk("j_jump", 32'(jump), 32'h1);
        chk("j_target", pc_jump, 32'h8000_0040);
        chk("j_pc_src", 32'(pc_src), 32'h0);
        adv();

        // write-through and r0
        if_id_instr = rtype(5'd7, 5'd0, 5'd3, 6'b100000);
        wb_set(5'd7, 32'hDEAD_BEEF);
        settle(); adv();
        side_clear();
        settle();
        chk("wt_rd1", id_ex_rd1, 32'hDEAD_BEEF);
        if_id_instr = rtype(5'd0, 5'd0, 5'd3, 6'b100000);
        wb_set(5'd0, 32'h1234_5678);
        adv();
        side_clear();
        settle();
        chk("r0_rd1", id_ex_rd1, 32'h0);
        chk("r0_rd2", id_ex_rd2, 32'h0);
        adv();

        // reset during a load-use stall
        if_id_instr = itype(6'b100011, 5'd1, 5'd2, 16'h0010);
        settle(); adv();
        if_id_instr = rtype(5'd2, 5'd7, 5'd3, 6'b100000);
        settle();
        chk("rst_pre_stall", 32'(stall_if), 32'h0);
        reset = 0;
        model_reset();
        #1;
        chk("rst_ctrl", 32'(id_ex_ctrl), 32'h0);
        chk("rst_rd1", id_ex_rd1, 32'h0);
        chk("rst_imm", id_ex_imm, 32'h0);
        chk("rst_regs", 32'(id_ex_regs), 32'h0);
        compare_model();
        adv();
        reset = 1;
        if_id_instr = rtype(5'd7, 5'd1, 5'd3, 6'b100000);
        settle(); adv();
        settle();
        chk("rf_clr_r7", id_ex_rd1, 32'h0);
        chk("rf_clr_r1", id_ex_rd2, 32'h0);
        adv();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            settle();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
